// File: rtl/turn_signal_ctrl_if.sv
// Switch inputs and sequencer enables of the turn-signal controller, bundled
// so the controller and its driver share one connection point.
interface turn_signal_ctrl_if;
  logic left_sw;
  logic right_sw;
  logic hazard_sw;
  logic left_ena;
  logic right_ena;
  logic hazard_active;

  // Drives the switches and observes the enables.
  modport master (
    output left_sw,
    output right_sw,
    output hazard_sw,
    input  left_ena,
    input  right_ena,
    input  hazard_active
  );

  // The controller itself.
  modport slave (
    input  left_sw,
    input  right_sw,
    input  hazard_sw,
    output left_ena,
    output right_ena,
    output hazard_active
  );
endinterface

// File: rtl/turn_signal_ctrl.sv
// Turn-signal mode controller: synchronizes and debounces the three stalk switches,
// arbitrates left/right/hazard, and forces a dead gap between different active modes.
module turn_signal_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int GAP_CYCLES      = 2
) (
  input logic               clk,
  input logic               rst,
  turn_signal_ctrl_if.slave bus
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      GAP_MAX  = 4'(GAP_CYCLES - 1);
  localparam int              SW_LEFT  = 0;
  localparam int              SW_RIGHT = 1;
  localparam int              SW_HAZ   = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GAP    = 3'd1,
    LEFT   = 3'd2,
    RIGHT  = 3'd3,
    HAZARD = 3'd4
  } state_e;

  logic [2:0]    raw_s;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    deb_q;
  logic [2:0]    deb_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  state_e        state_q;
  state_e        state_d;
  state_e        req_s;
  logic [3:0]    gap_cnt_q;
  logic [3:0]    gap_cnt_d;
  logic          left_ena_q;
  logic          left_ena_d;
  logic          right_ena_q;
  logic          right_ena_d;
  logic          hazard_q;
  logic          hazard_d;

  assign raw_s = {bus.hazard_sw, bus.right_sw, bus.left_sw};

  // Two-flop synchronizer on every raw switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Per-switch debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounced levels and their counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Requested mode; hazard wins, and left+right together is treated as no request.
  always_comb begin
    req_s = IDLE;
    if (deb_q[SW_HAZ]) begin
      req_s = HAZARD;
    end else if (deb_q[SW_LEFT] && deb_q[SW_RIGHT]) begin
      req_s = IDLE;
    end else if (deb_q[SW_LEFT]) begin
      req_s = LEFT;
    end else if (deb_q[SW_RIGHT]) begin
      req_s = RIGHT;
    end else begin
      req_s = IDLE;
    end
  end

  // Mode FSM next-state; switching between two active modes always passes through GAP.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        state_d   = req_s;
        gap_cnt_d = 4'd0;
      end
      LEFT, RIGHT, HAZARD: begin
        if (req_s == IDLE) begin
          state_d = IDLE;
        end else if (req_s != state_q) begin
          state_d   = GAP;
          gap_cnt_d = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_MAX) begin
          state_d   = req_s;
          gap_cnt_d = 4'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        gap_cnt_d = 4'd0;
      end
    endcase
  end

  // Mode FSM state and gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Output decode of the current state; unknown encodings decode to all-off.
  always_comb begin
    left_ena_d  = 1'b0;
    right_ena_d = 1'b0;
    hazard_d    = 1'b0;
    case (state_q)
      LEFT: begin
        left_ena_d = 1'b1;
      end
      RIGHT: begin
        right_ena_d = 1'b1;
      end
      HAZARD: begin
        left_ena_d  = 1'b1;
        right_ena_d = 1'b1;
        hazard_d    = 1'b1;
      end
      default: begin
        left_ena_d  = 1'b0;
        right_ena_d = 1'b0;
        hazard_d    = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_ena_q  <= 1'b0;
      right_ena_q <= 1'b0;
      hazard_q    <= 1'b0;
    end else begin
      left_ena_q  <= left_ena_d;
      right_ena_q <= right_ena_d;
      hazard_q    <= hazard_d;
    end
  end

  assign bus.left_ena      = left_ena_q;
  assign bus.right_ena     = right_ena_q;
  assign bus.hazard_active = hazard_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: directed scenarios plus random switch activity, every
// cycle compared against a behavioural model built from windows and mode rules.
module tb_turn_signal_ctrl;
  localparam int DEB  = 20;
  localparam int GAPC = 2;

  localparam int M_IDLE = 10;
  localparam int M_GAP  = 11;
  localparam int M_L    = 12;
  localparam int M_R    = 13;
  localparam int M_H    = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  turn_signal_ctrl_if bus ();

  turn_signal_ctrl #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit           m_s1 [3];
  bit           m_s2 [3];
  bit           m_deb [3];
  bit [DEB-1:0] m_win [3];
  int           m_state = M_IDLE;
  int           m_gap_rem = 0;
  bit           m_l, m_r, m_h;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int requested();
    if (m_deb[2]) return M_H;
    if (m_deb[0] && m_deb[1]) return M_IDLE;
    if (m_deb[0]) return M_L;
    if (m_deb[1]) return M_R;
    return M_IDLE;
  endfunction

  task automatic model_edge(input bit [2:0] raw, input bit r);
    int req;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_deb[i] = 1'b0; m_win[i] = '0;
      end
      m_state = M_IDLE; m_gap_rem = 0;
      m_l = 1'b0; m_r = 1'b0; m_h = 1'b0;
    end else begin
      req = requested();
      m_l = (m_state == M_L) || (m_state == M_H);
      m_r = (m_state == M_R) || (m_state == M_H);
      m_h = (m_state == M_H);
      if (m_state == M_IDLE) begin
        m_state = req;
      end else if (m_state == M_GAP) begin
        m_gap_rem--;
        if (m_gap_rem == 0) m_state = req;
      end else if (req == M_IDLE) begin
        m_state = M_IDLE;
      end else if (req != m_state) begin
        m_state = M_GAP; m_gap_rem = GAPC;
      end
      // a level is accepted once the last DEB synced samples all disagree with it
      for (int i = 0; i < 3; i++) begin
        m_win[i] = {m_win[i][DEB-2:0], m_s2[i]};
        if (m_deb[i] ? (m_win[i] == '0) : (&m_win[i])) m_deb[i] = ~m_deb[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  endtask

  task automatic step();
    bit [2:0] raw;
    bit       r;
    raw = {bus.hazard_sw, bus.right_sw, bus.left_sw};
    r   = rst;
    @(posedge clk);
    model_edge(raw, r);
    #1;
    check_val("left_ena", bus.left_ena, m_l);
    check_val("right_ena", bus.right_ena, m_r);
    check_val("hazard_active", bus.hazard_active, m_h);
  endtask

  task automatic set_sw(input bit l, input bit r, input bit h);
    bus.left_sw = l; bus.right_sw = r; bus.hazard_sw = h;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int lo;
    bit seen;
    int early;
    set_sw(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    // reset
    step();
    check_val("rst_left", bus.left_ena, 1'b0);
    check_val("rst_right", bus.right_ena, 1'b0);
    check_val("rst_haz", bus.hazard_active, 1'b0);
    steps(2);
    rst = 1'b0;
    steps(5);
    check_val("idle_left", bus.left_ena, 1'b0);

    // clean left edge latency
    set_sw(1'b1, 1'b0, 1'b0);
    steps(23);
    check_val("lat_23", bus.left_ena, 1'b0);
    step();
    check_val("lat_24", bus.left_ena, 1'b1);
    check_val("lat_right", bus.right_ena, 1'b0);

    // LEFT -> HAZARD through the gap
    set_sw(1'b1, 1'b0, 1'b1);
    lo = 0; seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      step();
      if (bus.hazard_active) seen = 1'b1;
      else if (!bus.left_ena && !bus.right_ena) lo++;
    end
    check_val("haz_reached", seen, 1'b1);
    check_val("gap_to_haz", lo, 2);
    check_val("haz_both", {bus.left_ena, bus.right_ena}, 2'b11);

    // HAZARD -> LEFT through the gap
    set_sw(1'b1, 1'b0, 1'b0);
    lo = 0; seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      step();
      if (bus.left_ena && !bus.right_ena && !bus.hazard_active) seen = 1'b1;
      else if (!bus.left_ena && !bus.right_ena) lo++;
    end
    check_val("left_back", seen, 1'b1);
    check_val("gap_to_left", lo, 2);
    set_sw(1'b0, 1'b0, 1'b0);
    steps(40);

    // bouncing left: 15 high, 3 low, then high
    early = 0;
    set_sw(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin step(); if (bus.left_ena) early++; end
    set_sw(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin step(); if (bus.left_ena) early++; end
    set_sw(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 23; k++) begin step(); if (bus.left_ena) early++; end
    check_val("bounce_early", early, 0);
    step();
    check_val("bounce_24", bus.left_ena, 1'b1);
    set_sw(1'b0, 1'b0, 1'b0);
    steps(40);

    // conflict, then release right
    set_sw(1'b1, 1'b1, 1'b0);
    steps(40);
    check_val("conf_l", bus.left_ena, 1'b0);
    check_val("conf_r", bus.right_ena, 1'b0);
    set_sw(1'b1, 1'b0, 1'b0);
    steps(23);
    check_val("unconf_23", bus.left_ena, 1'b0);
    step();
    check_val("unconf_24", bus.left_ena, 1'b1);

    // reset in RIGHT with the switch held
    set_sw(1'b0, 1'b1, 1'b0);
    steps(40);
    check_val("right_on", bus.right_ena, 1'b1);
    rst = 1'b1;
    step();
    check_val("rst_mid_r", bus.right_ena, 1'b0);
    rst = 1'b0;
    steps(23);
    check_val("rerun_23", bus.right_ena, 1'b0);
    step();
    check_val("rerun_24", bus.right_ena, 1'b1);

    // random activity
    for (int p = 0; p < 250; p++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        steps($urandom_range(1, 2));
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0, n = $urandom_range(1, 20); k < n; k++) begin
          set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          step();
        end
      end
      set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      steps($urandom_range(1, 50));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/turn_signal_ctrl.md
TURN_SIGNAL_CTRL -- requirements
Module: turn_signal_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20: consecutive stable cycles before a synced switch level is accepted; legal range 2..1023.
REQ-002 Parameter GAP_CYCLES, default 2: minimum cycles both enables are held low when switching between active modes; legal range 2..15.
REQ-003 clk  input  1  system clock; all state updates on rising edge; 1 kHz clock gives 20 ms debounce at the default.
REQ-004 rst  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-005 left_sw  input  1  raw left-turn switch, asynchronous to clk, may bounce.
REQ-006 right_sw  input  1  raw right-turn switch, asynchronous to clk, may bounce.
REQ-007 hazard_sw  input  1  raw hazard switch, asynchronous to clk, may bounce.
REQ-008 left_ena  output  1  enable to the left-side sequencer FSM.
REQ-009 right_ena  output  1  enable to the right-side sequencer FSM.
REQ-010 hazard_active  output  1  status; high only in HAZARD state.

Function
REQ-011 Each raw switch SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Each synced switch SHALL have its own debounce counter and debounced level register; the counter width is the minimum that holds DEBOUNCE_CYCLES-1.
REQ-013 Debounce: counter clears whenever the synced level equals the debounced level; it increments each cycle they differ; when it equals DEBOUNCE_CYCLES-1 and they still differ, the debounced level SHALL take the synced level and the counter SHALL clear.
REQ-014 Any synced pulse or bounce shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-015 FSM states SHALL be IDLE, GAP, LEFT, RIGHT, HAZARD; exactly one is active.
REQ-016 Requested mode from debounced levels, in priority order: hazard=1 -> HAZARD; left=1 and right=1 -> IDLE (conflict); left=1 -> LEFT; right=1 -> RIGHT; otherwise IDLE.
REQ-017 From IDLE, the FSM SHALL move to the requested mode on the next edge.
REQ-018 From LEFT, RIGHT or HAZARD, a request for IDLE SHALL move to IDLE; a request for a different active mode SHALL move to GAP.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles, counted by a gap counter cleared on entry. It then moves to the requested mode current at exit, or to IDLE if that request is IDLE.
REQ-020 Outputs SHALL be registered decodes of state: LEFT -> left_ena=1; RIGHT -> right_ena=1; HAZARD -> left_ena=1, right_ena=1, hazard_active=1; IDLE and GAP -> all 0.
REQ-021 Latency from a clean raw edge to an output change, with no gap, SHALL be 2 (sync) + DEBOUNCE_CYCLES (debounce) + 1 (state) + 1 (output register) cycles; this is 24 cycles at the default.
REQ-022 left_ena and right_ena SHALL never go from one active mode to a different active mode without at least GAP_CYCLES cycles with both low.
REQ-023 Illegal state encodings SHALL return to IDLE on the next edge with all outputs 0.

Reset
REQ-024 When rst=1 at an edge, the following SHALL be cleared on that edge regardless of state or counters mid-count: synchronizer flops, debounced levels, debounce counters, gap counter, and all outputs. The state SHALL go to IDLE.
REQ-025 After rst falls, switches already held high SHALL be treated as new edges and produce outputs after the full REQ-021 latency.

Verification
REQ-026 Reset, all switches 0 -> left_ena=0, right_ena=0, hazard_active=0 on the first edge with rst=1 and after it.
REQ-027 left_sw 0->1 clean at cycle 0 (defaults) -> left_ena=1 at cycle 24; right_ena stays 0.
REQ-028 left_sw bounces high for 15 cycles, low for 3, high thereafter -> left_ena rises 24 cycles after the final rising edge; no earlier pulse.
REQ-029 In LEFT, hazard_sw held high -> both enables low for exactly 2 cycles (GAP), then left_ena=1, right_ena=1, hazard_active=1. Releasing hazard_sw while left_sw is still high -> 2 low cycles, then left_ena only.
REQ-030 left_sw and right_sw both high -> both enables 0; releasing right_sw -> left_ena=1 after REQ-021 latency.
REQ-031 In RIGHT, rst asserted for 1 cycle -> all outputs 0 on that edge; right_sw still high -> right_ena=1 again 24 cycles after rst falls.
